// File: rtl/decode_stage_ctrl.sv
// IF/ID pipeline register control: valid/ready capture, legal issue to execute,
// illegal-instruction trap handshake, flush, and a saturating illegal counter.
module decode_stage_ctrl #(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 16,
    parameter int TRAP_CAUSE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [XLEN-1:0]  fetch_insn,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic [XLEN-1:0]  dec_insn,
    input  logic             illegal_insn,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_pc,
    input  logic             ex_ready,
    input  logic             flush,
    output logic             trap_req,
    output logic [4:0]       trap_cause,
    output logic [XLEN-1:0]  trap_tval,
    output logic [XLEN-1:0]  trap_pc,
    input  logic             trap_ack,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        TRAP  = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   insn_q;
    logic [XLEN-1:0]   pc_q;
    logic [CNT_W-1:0]  count_q;
    logic              capture;

    // Handshake outputs are held low while reset is asserted so nothing is
    // accepted or issued before the pipeline is known to be empty.
    always_comb begin
        fetch_ready = 1'b0;
        id_valid    = 1'b0;
        if (rst_n && !flush) begin
            fetch_ready = (state == EMPTY) ||
                          ((state == HELD) && !illegal_insn && ex_ready);
            id_valid    = (state == HELD) && !illegal_insn;
        end
    end

    assign capture       = fetch_valid && fetch_ready;
    assign trap_req      = rst_n && (state == TRAP);
    assign trap_cause    = trap_req ? 5'(TRAP_CAUSE) : 5'd0;
    assign trap_tval     = trap_req ? insn_q : '0;
    assign trap_pc       = trap_req ? pc_q : '0;
    assign dec_insn      = insn_q;
    assign id_pc         = pc_q;
    assign illegal_count = count_q;

    // The held register only loads on an accepted fetch, so it stays frozen
    // through TRAP and after a flush without extra qualification here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= EMPTY;
            insn_q  <= '0;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            if (capture) begin
                insn_q <= fetch_insn;
                pc_q   <= fetch_pc;
            end
            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (fetch_valid) state <= HELD;
                    end
                    HELD: begin
                        if (illegal_insn) begin
                            state <= TRAP;
                            if (count_q != '1) count_q <= count_q + CNT_W'(1);
                        end else if (ex_ready && !fetch_valid) begin
                            state <= EMPTY;
                        end
                    end
                    TRAP: begin
                        if (trap_ack) state <= EMPTY;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Self-checking bench for decode_stage_ctrl: per-cycle vector table through a
// scoreboard queue, plus a hand-written counter saturation sequence.
module tb_decode_stage_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
    localparam logic [31:0] ILL = 32'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fetch_valid;
    logic             fetch_ready;
    logic [XLEN-1:0]  fetch_insn;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  dec_insn;
    logic             illegal_insn;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic             ex_ready;
    logic             flush;
    logic             trap_req;
    logic [4:0]       trap_cause;
    logic [XLEN-1:0]  trap_tval;
    logic [XLEN-1:0]  trap_pc;
    logic             trap_ack;
    logic [CNT_W-1:0] illegal_count;

    decode_stage_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .TRAP_CAUSE(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_insn(fetch_insn), .fetch_pc(fetch_pc),
        .dec_insn(dec_insn), .illegal_insn(illegal_insn),
        .id_valid(id_valid), .id_pc(id_pc),
        .ex_ready(ex_ready), .flush(flush),
        .trap_req(trap_req), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .trap_pc(trap_pc),
        .trap_ack(trap_ack), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    // Stand-in decoder: only the all-ones word is treated as illegal.
    assign illegal_insn = (dec_insn == ILL);

    typedef struct {
        logic        rst_n, fv;
        logic [31:0] insn, pc;
        logic        exr, fl, ack;
        logic        fr, idv;
        logic [31:0] idpc, dinsn;
        logic        treq;
        logic [4:0]  tcause;
        logic [31:0] tval, tpc;
        logic [1:0]  cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   cnt_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void add(input logic r, fv, input logic [31:0] insn, pc,
                                input logic exr, fl, ack, fr, idv,
                                input logic [31:0] idpc, dinsn,
                                input logic treq, input logic [1:0] cnt);
        vec_t v;
        v.rst_n = r;  v.fv = fv;   v.insn = insn; v.pc = pc;
        v.exr = exr;  v.fl = fl;   v.ack = ack;
        v.fr = fr;    v.idv = idv; v.idpc = idpc; v.dinsn = dinsn;
        v.treq = treq;
        v.tcause = treq ? 5'd2 : 5'd0;
        v.tval   = treq ? dinsn : 32'd0;
        v.tpc    = treq ? idpc : 32'd0;
        v.cnt  = cnt;
        tbl.push_back(v);
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n       = v.rst_n;
        fetch_valid = v.fv;
        fetch_insn  = v.insn;
        fetch_pc    = v.pc;
        ex_ready    = v.exr;
        flush       = v.fl;
        trap_ack    = v.ack;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        if (exp_q.size() == 0) begin
            checkField($sformatf("v%0d.scoreboard_empty", idx), 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        checkField($sformatf("v%0d.fetch_ready", idx), 32'(fetch_ready), 32'(e.fr));
        checkField($sformatf("v%0d.id_valid", idx), 32'(id_valid), 32'(e.idv));
        checkField($sformatf("v%0d.id_pc", idx), id_pc, e.idpc);
        checkField($sformatf("v%0d.dec_insn", idx), dec_insn, e.dinsn);
        checkField($sformatf("v%0d.trap_req", idx), 32'(trap_req), 32'(e.treq));
        checkField($sformatf("v%0d.trap_cause", idx), 32'(trap_cause), 32'(e.tcause));
        checkField($sformatf("v%0d.trap_tval", idx), trap_tval, e.tval);
        checkField($sformatf("v%0d.trap_pc", idx), trap_pc, e.tpc);
        checkField($sformatf("v%0d.illegal_count", idx), 32'(illegal_count), 32'(e.cnt));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        rst_n = 1'b0; fetch_valid = 1'b0; fetch_insn = '0; fetch_pc = '0;
        ex_ready = 1'b0; flush = 1'b0; trap_ack = 1'b0;

        //   rst fv insn          pc        exr fl ack  fr idv idpc      dinsn         treq cnt
        // reset and first capture
        add(0, 1, 32'h00500093, 32'h100, 1, 0, 0,  0, 0, 32'h0,    32'h0,        0, 0);
        add(0, 1, 32'h00500093, 32'h100, 1, 0, 0,  0, 0, 32'h0,    32'h0,        0, 0);
        add(1, 1, 32'h00500093, 32'h100, 0, 0, 0,  1, 0, 32'h0,    32'h0,        0, 0);
        add(1, 0, 32'h0,        32'h0,   0, 0, 0,  0, 1, 32'h100,  32'h00500093, 0, 0);
        add(1, 0, 32'h0,        32'h0,   1, 0, 0,  1, 1, 32'h100,  32'h00500093, 0, 0);
        // back-to-back stream
        add(1, 1, 32'h00000013, 32'h0,   1, 0, 0,  1, 0, 32'h100,  32'h00500093, 0, 0);
        add(1, 1, 32'h00100093, 32'h4,   1, 0, 0,  1, 1, 32'h0,    32'h00000013, 0, 0);
        add(1, 1, 32'h00200093, 32'h8,   1, 0, 0,  1, 1, 32'h4,    32'h00100093, 0, 0);
        add(1, 1, 32'h00300093, 32'hC,   1, 0, 0,  1, 1, 32'h8,    32'h00200093, 0, 0);
        add(1, 0, 32'h0,        32'h0,   1, 0, 0,  1, 1, 32'hC,    32'h00300093, 0, 0);
        // backpressure
        add(1, 1, 32'h00400093, 32'h10,  0, 0, 0,  1, 0, 32'hC,    32'h00300093, 0, 0);
        add(1, 1, 32'h00500093, 32'h14,  0, 0, 0,  0, 1, 32'h10,   32'h00400093, 0, 0);
        add(1, 1, 32'h00500093, 32'h14,  0, 0, 0,  0, 1, 32'h10,   32'h00400093, 0, 0);
        add(1, 1, 32'h00500093, 32'h14,  0, 0, 0,  0, 1, 32'h10,   32'h00400093, 0, 0);
        add(1, 1, 32'h00500093, 32'h14,  1, 0, 0,  1, 1, 32'h10,   32'h00400093, 0, 0);
        add(1, 0, 32'h0,        32'h0,   1, 0, 0,  1, 1, 32'h14,   32'h00500093, 0, 0);
        // illegal instruction trap with delayed ack
        add(1, 1, ILL,          32'h200, 1, 0, 0,  1, 0, 32'h14,   32'h00500093, 0, 0);
        add(1, 1, 32'h00600093, 32'h204, 1, 0, 0,  0, 0, 32'h200,  ILL,          0, 0);
        add(1, 1, 32'h00600093, 32'h204, 1, 0, 0,  0, 0, 32'h200,  ILL,          1, 1);
        add(1, 1, 32'h00600093, 32'h204, 1, 0, 0,  0, 0, 32'h200,  ILL,          1, 1);
        add(1, 1, 32'h00600093, 32'h204, 1, 0, 1,  0, 0, 32'h200,  ILL,          1, 1);
        add(1, 0, 32'h0,        32'h0,   1, 0, 0,  1, 0, 32'h200,  ILL,          0, 1);
        // flush while trapped, then flush against a fetch
        add(1, 1, ILL,          32'h300, 1, 0, 0,  1, 0, 32'h200,  ILL,          0, 1);
        add(1, 0, 32'h0,        32'h0,   1, 0, 0,  0, 0, 32'h300,  ILL,          0, 1);
        add(1, 0, 32'h0,        32'h0,   1, 0, 0,  0, 0, 32'h300,  ILL,          1, 2);
        add(1, 0, 32'h0,        32'h0,   1, 1, 0,  0, 0, 32'h300,  ILL,          1, 2);
        add(1, 1, 32'h00700093, 32'h400, 1, 1, 0,  0, 0, 32'h300,  ILL,          0, 2);
        add(1, 0, 32'h0,        32'h0,   1, 0, 0,  1, 0, 32'h300,  ILL,          0, 2);
        // flush kills a legal held instruction
        add(1, 1, 32'h00800093, 32'h500, 0, 0, 0,  1, 0, 32'h300,  ILL,          0, 2);
        add(1, 1, 32'h00900093, 32'h504, 1, 1, 0,  0, 0, 32'h500,  32'h00800093, 0, 2);
        add(1, 0, 32'h0,        32'h0,   1, 0, 0,  1, 0, 32'h500,  32'h00800093, 0, 2);

        @(posedge clk);
        foreach (tbl[i]) begin
            #1 applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput(i);
            @(posedge clk);
        end

        // Counter saturation: fresh reset, then five illegal words each acked;
        // the third exit uses flush together with ack.
        #1 rst_n = 1'b0; fetch_valid = 1'b0; flush = 1'b0; trap_ack = 1'b0;
        @(negedge clk);
        checkField("sat.reset_fetch_ready", 32'(fetch_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkField("sat.count_after_reset", 32'(illegal_count), 32'd0);
        checkField("sat.dec_insn_after_reset", dec_insn, 32'd0);
        for (int k = 0; k < 5; k++) begin
            fetch_valid = 1'b1;
            fetch_insn  = ILL;
            fetch_pc    = 32'h600 + 32'(4 * k);
            @(posedge clk);
            #1 fetch_valid = 1'b0;
            w = 0;
            while (!trap_req && w < 4) begin
                @(posedge clk);
                #1 w++;
            end
            checkField($sformatf("sat%0d.trap_req", k), 32'(trap_req), 32'd1);
            checkField($sformatf("sat%0d.trap_latency", k), 32'(w), 32'd1);
            checkField($sformatf("sat%0d.trap_pc", k), trap_pc, 32'h600 + 32'(4 * k));
            trap_ack = 1'b1;
            flush    = (k == 2);
            cnt_q.push_back((k + 1 > 3) ? 3 : k + 1);
            @(posedge clk);
            #1 trap_ack = 1'b0; flush = 1'b0;
            @(negedge clk);
            checkField($sformatf("sat%0d.trap_req_after_ack", k), 32'(trap_req), 32'd0);
            checkField($sformatf("sat%0d.illegal_count", k), 32'(illegal_count), 32'(cnt_q.pop_front()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
